// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU control unit: default widths, controller
// states, instruction-type encoding and the jump condition decode.
package hack_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned AW_DEF = 15;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC
    } state_t;

    localparam logic A_INSTR = 1'b0;
    localparam logic C_INSTR = 1'b1;

    // j = {j1,j2,j3}: jump on negative, zero, positive result respectively.
    function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
        return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_pc.sv
// Hack program counter: async-reset register with jump load and wrapping increment.
module hack_pc
    import hack_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [AW-1:0] i_target,
    input  logic          i_inc,
    output logic [AW-1:0] o_pc
);

    logic [AW-1:0] r_pc;

    // Load wins over increment; increment wraps naturally at 2^AW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + AW'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/hack_ctrl.sv
// Multi-cycle Hack CPU controller: fetch/decode/execute sequencing, instruction
// register, register load strobes, data-memory write handshake and next-PC.
module hack_ctrl
    import hack_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run_en,
    output logic          instr_req,
    output logic [AW-1:0] pc,
    input  logic [DW-1:0] instr_rdata,
    input  logic          instr_rvalid,
    output logic [DW-1:0] ir,
    input  logic          instr_type,
    input  logic [2:0]    cmd_d,
    input  logic [2:0]    cmd_j,
    input  logic          alu_zr,
    input  logic          alu_ng,
    input  logic [AW-1:0] a_reg,
    output logic          a_load,
    output logic          a_sel,
    output logic          d_load,
    output logic          m_we,
    input  logic          m_ack,
    output logic          instr_done
);

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_ir;
    logic          w_is_c;
    logic          w_wr_wait;
    logic          w_retire;
    logic          w_jump;
    logic          w_pc_load;
    logic          w_pc_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir <= '0;
        end else if (r_state == FETCH && instr_rvalid) begin
            r_ir <= instr_rdata;
        end
    end

    assign w_is_c    = (instr_type == C_INSTR);
    assign w_wr_wait = cmd_d[0] & ~m_ack;

    always_comb begin
        w_next    = r_state;
        instr_req = 1'b0;
        a_load    = 1'b0;
        a_sel     = 1'b0;
        d_load    = 1'b0;
        m_we      = 1'b0;
        w_retire  = 1'b0;
        case (r_state)
            IDLE: begin
                if (run_en) begin
                    w_next = FETCH;
                end
            end
            FETCH: begin
                instr_req = 1'b1;
                if (instr_rvalid) begin
                    w_next = DECODE;
                end
            end
            DECODE: begin
                w_next = EXEC;
            end
            EXEC: begin
                if (!w_is_c) begin
                    a_load   = 1'b1;
                    w_retire = 1'b1;
                end else begin
                    // A/D loads are held back until the write is acked so M
                    // is written at the pre-update A address.
                    a_sel    = 1'b1;
                    m_we     = cmd_d[0];
                    a_load   = cmd_d[2] & ~w_wr_wait;
                    d_load   = cmd_d[1] & ~w_wr_wait;
                    w_retire = ~w_wr_wait;
                end
                if (w_retire) begin
                    w_next = run_en ? FETCH : IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_jump     = w_retire & w_is_c & jump_taken(cmd_j, alu_zr, alu_ng);
    assign w_pc_load  = w_jump;
    assign w_pc_inc   = w_retire & ~w_jump;
    assign instr_done = w_retire;
    assign ir         = r_ir;

    hack_pc #(
        .AW(AW)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_pc_load),
        .i_target (a_reg),
        .i_inc    (w_pc_inc),
        .o_pc     (pc)
    );

endmodule

// File: tb/tb_hack_ctrl.sv
// Bench for hack_ctrl: directed instruction table plus randomized instructions
// checked cycle by cycle against a per-instruction reference model.
module tb_hack_ctrl;

    localparam int DW = 16;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          run_en;
    logic          instr_req;
    logic [AW-1:0] pc;
    logic [DW-1:0] instr_rdata;
    logic          instr_rvalid;
    logic [DW-1:0] ir;
    logic          instr_type;
    logic [2:0]    cmd_d;
    logic [2:0]    cmd_j;
    logic          alu_zr;
    logic          alu_ng;
    logic [AW-1:0] a_reg;
    logic          a_load;
    logic          a_sel;
    logic          d_load;
    logic          m_we;
    logic          m_ack;
    logic          instr_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [AW-1:0] m_pc = '0;

    always #5 clk = ~clk;

    // Stand-in for instr_demux
    assign instr_type = ir[15];
    assign cmd_d      = ir[5:3];
    assign cmd_j      = ir[2:0];

    hack_ctrl #(
        .DW(DW),
        .AW(AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run_en       (run_en),
        .instr_req    (instr_req),
        .pc           (pc),
        .instr_rdata  (instr_rdata),
        .instr_rvalid (instr_rvalid),
        .ir           (ir),
        .instr_type   (instr_type),
        .cmd_d        (cmd_d),
        .cmd_j        (cmd_j),
        .alu_zr       (alu_zr),
        .alu_ng       (alu_ng),
        .a_reg        (a_reg),
        .a_load       (a_load),
        .a_sel        (a_sel),
        .d_load       (d_load),
        .m_we         (m_we),
        .m_ack        (m_ack),
        .instr_done   (instr_done)
    );

    typedef struct {
        logic [15:0] instr;
        logic        zr;
        logic        ng;
        logic [14:0] areg;
        int          rom_wait;
        int          ack_wait;
        logic        run_after;
        logic        exp_a;
        logic        exp_d;
        logic        exp_m;
        logic        exp_asel;
        logic [14:0] exp_pc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] instr, input logic zr, input logic ng,
                                input logic [14:0] areg, input int rw, input int aw,
                                input logic ra, input logic ea, input logic ed,
                                input logic em, input logic es, input logic [14:0] ep);
        vec_t v;
        v.instr = instr; v.zr = zr; v.ng = ng; v.areg = areg;
        v.rom_wait = rw; v.ack_wait = aw; v.run_after = ra;
        v.exp_a = ea; v.exp_d = ed; v.exp_m = em; v.exp_asel = es; v.exp_pc = ep;
        return v;
    endfunction

    // Reference: classify the ALU result as <0 / ==0 / >0 and look up the jump bit.
    function automatic vec_t model(input vec_t vin, input logic [14:0] cur_pc);
        vec_t       v;
        int         cls;
        logic [2:0] jb;
        logic       taken;
        v = vin;
        if (!v.instr[15]) begin
            v.exp_a = 1'b1; v.exp_d = 1'b0; v.exp_m = 1'b0; v.exp_asel = 1'b0;
            taken = 1'b0;
        end else begin
            v.exp_a = v.instr[5]; v.exp_d = v.instr[4]; v.exp_m = v.instr[3];
            v.exp_asel = 1'b1;
            cls = v.ng ? 0 : (v.zr ? 1 : 2);
            jb = v.instr[2:0];
            taken = jb[2-cls];
        end
        v.exp_pc = taken ? v.areg : 15'((int'(cur_pc) + 1) % 32768);
        return v;
    endfunction

    task automatic run_instr(input vec_t v);
        bit last;
        for (int w = 0; w <= v.rom_wait; w++) begin
            @(negedge clk);
            instr_rvalid = (w == v.rom_wait);
            instr_rdata  = (w == v.rom_wait) ? v.instr : 16'($urandom);
            m_ack        = 1'($urandom_range(0, 1));
            #1;
            chk("fetch_req", instr_req, 1);
            chk("fetch_pc", pc, m_pc);
            chk("fetch_done", instr_done, 0);
            chk("fetch_strobes", {a_load, d_load, m_we}, 0);
        end
        @(negedge clk);
        instr_rvalid = 1'($urandom_range(0, 1));
        instr_rdata  = 16'($urandom);
        run_en = v.run_after;
        alu_zr = v.zr;
        alu_ng = v.ng;
        a_reg  = v.areg;
        #1;
        chk("decode_ir", ir, v.instr);
        chk("decode_req", instr_req, 0);
        chk("decode_strobes", {a_load, d_load, m_we}, 0);
        chk("decode_done", instr_done, 0);
        if (v.exp_m) begin
            for (int k = 0; k <= v.ack_wait; k++) begin
                last = (k == v.ack_wait);
                @(negedge clk);
                m_ack = last;
                instr_rvalid = 1'($urandom_range(0, 1));
                #1;
                chk("wr_m_we", m_we, 1);
                chk("wr_a_load", a_load, v.exp_a & last);
                chk("wr_d_load", d_load, v.exp_d & last);
                chk("wr_a_sel", a_sel, 1);
                chk("wr_done", instr_done, last);
                chk("wr_pc", pc, m_pc);
            end
        end else begin
            @(negedge clk);
            m_ack = 1'($urandom_range(0, 1));
            instr_rvalid = 1'($urandom_range(0, 1));
            #1;
            chk("exec_a_load", a_load, v.exp_a);
            chk("exec_d_load", d_load, v.exp_d);
            chk("exec_m_we", m_we, 0);
            chk("exec_a_sel", a_sel, v.exp_asel);
            chk("exec_done", instr_done, 1);
        end
        m_pc = v.exp_pc;
    endtask

    task automatic idle_then_resume(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            chk("idle_req", instr_req, 0);
            chk("idle_pc", pc, m_pc);
            chk("idle_done", instr_done, 0);
            chk("idle_strobes", {a_load, d_load, m_we, a_sel}, 0);
        end
        @(negedge clk);
        run_en = 1'b1;
        #1;
        chk("resume_req_low", instr_req, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int   cls;

        rst = 1'b1; run_en = 1'b0; instr_rvalid = 1'b0; instr_rdata = '0;
        alu_zr = 1'b0; alu_ng = 1'b0; a_reg = '0; m_ack = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_ir", ir, 0);
        chk("rst_req", instr_req, 0);
        chk("rst_outs", {a_load, a_sel, d_load, m_we, instr_done}, 0);
        @(negedge clk);
        rst = 1'b0; run_en = 1'b1;
        #1;
        chk("rel_req", instr_req, 0);

        tbl.push_back(mk(16'h0005,               0, 0, 15'd0,     0, 0, 1, 1, 0, 0, 0, 15'd1));
        tbl.push_back(mk(16'b111_0_101010_000_111, 0, 0, 15'd5,   1, 0, 1, 0, 0, 0, 1, 15'd5));
        tbl.push_back(mk(16'h7FFF,               0, 0, 15'd0,     0, 0, 1, 1, 0, 0, 0, 15'd6));
        tbl.push_back(mk(16'b111_0_000010_010_000, 0, 0, 15'd9,   0, 0, 1, 0, 1, 0, 1, 15'd7));
        tbl.push_back(mk(16'b111_0_110111_001_000, 0, 0, 15'd9,   0, 3, 1, 0, 0, 1, 1, 15'd8));
        tbl.push_back(mk(16'b111_0_001100_000_001, 0, 0, 15'd100, 0, 0, 1, 0, 0, 0, 1, 15'd100));
        tbl.push_back(mk(16'b111_0_001100_000_001, 1, 0, 15'd100, 0, 0, 1, 0, 0, 0, 1, 15'd101));
        tbl.push_back(mk(16'b111_0_001100_000_001, 0, 1, 15'd100, 0, 0, 1, 0, 0, 0, 1, 15'd102));
        tbl.push_back(mk(16'b111_0_101010_000_111, 0, 1, 15'd100, 0, 0, 1, 0, 0, 0, 1, 15'd100));
        tbl.push_back(mk(16'b111_0_101010_000_111, 1, 0, 15'd100, 0, 0, 1, 0, 0, 0, 1, 15'd100));
        tbl.push_back(mk(16'b111_0_101010_000_111, 0, 0, 15'd32767, 0, 0, 1, 0, 0, 0, 1, 15'd32767));
        tbl.push_back(mk(16'h1234,               0, 0, 15'd7,     0, 0, 1, 1, 0, 0, 0, 15'd0));
        tbl.push_back(mk(16'b111_0_101010_000_111, 0, 0, 15'd0,   0, 0, 1, 0, 0, 0, 1, 15'd0));
        tbl.push_back(mk(16'b111_0_000000_111_000, 0, 0, 15'd50,  2, 0, 1, 1, 1, 1, 1, 15'd1));
        tbl.push_back(mk(16'h0ABC,               0, 0, 15'd0,     0, 0, 0, 1, 0, 0, 0, 15'd2));

        foreach (tbl[i]) begin
            run_instr(tbl[i]);
            if (!tbl[i].run_after) idle_then_resume(3);
        end

        for (int n = 0; n < 40; n++) begin
            v.instr = ($urandom_range(0, 1) == 1) ? {3'b111, 13'($urandom)} : {1'b0, 15'($urandom)};
            cls = $urandom_range(0, 2);
            v.ng = (cls == 0);
            v.zr = (cls == 1);
            v.areg = 15'($urandom);
            v.rom_wait = $urandom_range(0, 2);
            v.ack_wait = $urandom_range(0, 3);
            v.run_after = ($urandom_range(0, 7) != 0);
            v = model(v, m_pc);
            run_instr(v);
            if (!v.run_after) idle_then_resume($urandom_range(1, 3));
        end

        // Asynchronous reset while a write is pending in EXEC
        @(negedge clk);
        instr_rvalid = 1'b1;
        instr_rdata  = 16'b111_0_000000_111_000;
        #1;
        chk("mid_fetch_req", instr_req, 1);
        @(negedge clk);
        instr_rvalid = 1'b0;
        run_en = 1'b1;
        #1;
        chk("mid_decode_ir", ir, 16'hE038);
        @(negedge clk);
        m_ack = 1'b0;
        #1;
        chk("mid_exec_m_we", m_we, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_pc", pc, 0);
        chk("arst_ir", ir, 0);
        chk("arst_m_we", m_we, 0);
        chk("arst_req", instr_req, 0);
        chk("arst_outs", {a_load, a_sel, d_load, instr_done}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_rel_req", instr_req, 0);
        @(negedge clk);
        #1;
        chk("arst_fetch_req", instr_req, 1);
        chk("arst_fetch_pc", pc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hack_ctrl.md
Name: hack_ctrl

Overview:
Multi-cycle control unit for the Hack CPU. It sequences fetch, decode and execute around instr_demux, the A/D registers, the ALU and data memory. It owns the program counter and the instruction register, and feeds the instruction register to instr_demux. From the demuxed d/j fields and the ALU flags it generates register load strobes, the memory write handshake and the next PC.

Parameters:
DW, 16, instruction/data width
AW, 15, instruction/data address width (PC and A-register address part)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
run_en  in  1  enable; low parks the controller in IDLE at the next instruction boundary
instr_req  out  1  instruction fetch request, held until instr_rvalid
pc  out  AW  current program counter (instruction ROM address)
instr_rdata  in  DW  instruction word from ROM
instr_rvalid  in  1  instr_rdata valid; may assert in the same cycle as instr_req
ir  out  DW  latched instruction, drives instr_demux.instr
instr_type  in  1  from instr_demux: 0 = A-instruction, 1 = C-instruction
cmd_d  in  3  {d1,d2,d3} from instr_demux
cmd_j  in  3  {j1,j2,j3} from instr_demux
alu_zr  in  1  ALU result == 0
alu_ng  in  1  ALU result < 0
a_reg  in  AW  current A-register value (jump target)
a_load  out  1  A-register load strobe
a_sel  out  1  A input select: 0 = instruction value (ir[DW-2:0]), 1 = ALU out
d_load  out  1  D-register load strobe
m_we  out  1  data memory write request, held until m_ack
m_ack  in  1  data memory write accepted
instr_done  out  1  one-cycle pulse when an instruction retires

Behaviour:
- Reset (async, any state): state=IDLE, pc=0, ir=0. All strobes, instr_req and instr_done are 0. Any outstanding fetch or write is abandoned. a_sel=0.
- States: IDLE, FETCH, DECODE, EXEC.
- IDLE: all outputs inactive. Moves to FETCH on the clock edge where run_en=1.
- FETCH: instr_req=1, pc stable. On the clock edge with instr_rvalid=1, ir<=instr_rdata and state moves to DECODE. Minimum 1 cycle.
- DECODE: exactly 1 cycle. Lets instr_demux and the ALU settle on the new ir. No strobes.
- EXEC, A-instruction: a_load=1 and a_sel=0 for one cycle, then pc<=pc+1.
- EXEC, C-instruction: a_sel=1. a_load=d1, d_load=d2 and m_we=d3 (combinational in EXEC).
- EXEC, C-instruction with d3=1: m_we is held and the state stays in EXEC until m_ack=1. a_load and d_load are masked to 0 until the ack cycle, then assert together with it. The A/D update and the M write therefore commit in the same cycle, and M is addressed by the pre-update A.
- EXEC retire cycle (no write, or m_ack=1):
  - instr_done=1.
  - pc<=a_reg if jump, else pc+1.
  - jump = instr_type & ((j1&alu_ng) | (j2&alu_zr) | (j3&~alu_ng&~alu_zr)); j=111 therefore jumps unconditionally.
  - Next state is FETCH if run_en=1, else IDLE.
- PC width: pc+1 wraps from 2^AW-1 to 0. A jump uses a_reg[AW-1:0] unchanged.
- Latency: A-instruction or C-instruction without write takes 3 cycles with zero-wait ROM; a write adds the m_ack wait cycles.
- run_en=0 mid-instruction does not abort; it takes effect only at retire. From IDLE, execution resumes at the held pc.
- instr_rvalid outside FETCH and m_ack outside EXEC-with-write are ignored.

Decomposition:
- Shared package hack_pkg holds:
  - DW/AW defaults;
  - state enum (IDLE, FETCH, DECODE, EXEC);
  - A_INSTR/C_INSTR constants;
  - function jump_taken(j[2:0], zr, ng).
- One sub-module hack_pc: the AW-bit register with async reset, load (target) and inc inputs, inc wrapping at 2^AW. The FSM and strobe decode stay in hack_ctrl.

Test Plan:
1. Reset mid-EXEC with m_we=1 -> pc=0, ir=0, m_we=0, state IDLE immediately; after release with run_en=1, instr_req rises one cycle later.
2. Zero-wait ROM at pc=5 with ir=16'h7FFF -> a_load=1 and a_sel=0 in cycle 3, instr_done pulse, pc=6, FETCH again.
3. C-instruction 111_0_000010_010_000 -> d_load=1 with a_load=0 and m_we=0, pc+1. Then 111_0_110111_001_000 with m_ack delayed 3 cycles -> m_we held 4 cycles, retire on ack cycle only.
4. C-instruction 111_0_001100_000_001 (JGT), a_reg=100: zr=0, ng=0 -> pc=100; zr=1 -> pc+1; ng=1 -> pc+1. j=111 -> pc=100 always.
5. pc=32767 with a non-jump instruction -> pc=0 after retire. Jump to a_reg=0 -> pc=0.
6. run_en dropped during DECODE -> instruction still retires with instr_done=1, then IDLE with pc held. Raise run_en -> fetch resumes at the same pc.
